csi2_lane_sync: RTL and testbench
=================================

// Module: csi2_lane_sync
// PURPOSE
//  Per-lane HS sync-byte hunter and byte aligner for the CSI-2 D-PHY receive path.
//  Consumes 2 bits/clk from the lane's DDR input registers (IFS1P3DX pair) and locates
//  the HS leader sync byte at either bit phase. After lock it emits aligned bytes
//  every 4 clk to the lane merger. One instance per data lane.
// PARAMETERS
//  SYNC_BYTE     8'hB8  HS sync pattern; serial order is LSB first
//  HUNT_TIMEOUT  64     clk spent in HUNT without a match before sync_err (>=2)
//  SYNC_TOL      0      1 = also accept sync with exactly one bit error; 0 = exact match only
// PORTS
//  clk           in   1  byte-phase/4 lane clock (DDR register SCLK)
//  rst           in   1  asynchronous reset, active-high
//  hs_active     in   1  lane is in HS mode (LP-state detector); low = LP-11/stop
//  din           in   2  DDR sample pair; din[0] received before din[1]
//  byte_out      out  8  aligned byte; bit0 = first received bit
//  byte_valid    out  1  1-clk strobe; byte_out valid this cycle
//  pkt_start     out  1  coincides with byte_valid of the first byte after sync
//  locked        out  1  sync found; high for the rest of the HS burst
//  bit_phase     out  1  alignment found: 0 = sr[9:2], 1 = sr[8:1]
//  sync_err      out  1  1-clk pulse on HUNT timeout
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, sr=0, counters=0.
//   Outputs byte_out=0, byte_valid=0, pkt_start=0, locked=0, bit_phase=0, sync_err=0.
//  Shift register sr[9:0] updates every clk in all states: sr <= {din[1], din[0], sr[9:2]}.
//  Match (combinational on registered sr):
//   m0 = (sr[9:2]==SYNC_BYTE); m1 = (sr[8:1]==SYNC_BYTE).
//   With SYNC_TOL=1, Hamming distance <=1 also counts as a match.
//   If both match, m0 wins.
//  States:
//   IDLE: hs_active=1 -> HUNT; clear hunt counter.
//   HUNT: hunt counter +1/clk.
//     m0|m1 -> SYNC: locked<=1, bit_phase<=~m0, byte counter=0, first<=1.
//     Else counter==HUNT_TIMEOUT-1 -> WAIT_LP with sync_err pulse.
//   SYNC: byte counter 0..3, wraps.
//     When counter==3: byte_out <= phase window (sr[9:2] or sr[8:1]), byte_valid=1,
//     pkt_start=first; then first<=0.
//   WAIT_LP: no output; sync_err must not re-pulse. Stays here until hs_active=0.
//  hs_active=0 in any state -> IDLE on the next edge.
//   locked, byte_valid and pkt_start fall in that same edge.
//   A partially assembled byte is discarded; sr keeps shifting.
//  Timing: sync match visible in sr at edge T -> locked high from edge T+1.
//   First data byte strobed at edge T+4 (byte_valid high in cycle after T+4).
//   Bytes strobe every 4 clk thereafter.
//  byte_valid is never high on consecutive cycles. byte_out holds its value between strobes.
//  No re-hunt within a burst: sync-like data in SYNC state is ignored.
//  Counters saturate-free. Hunt counter width = clog2(HUNT_TIMEOUT).
//   Byte counter = 2 bits and wraps 3->0.
// TESTING
//  Phase 0 lock:
//   hs_active=1, feed bits 00000000 then 0xB8, 0x12, 0x34 LSB-first at phase 0
//   -> locked, bit_phase=0, bytes 12,34 with pkt_start on 12, 4-clk spacing.
//  Phase 1 lock:
//   same stream preceded by 1 extra zero bit -> bit_phase=1, identical bytes 12,34.
//  Timeout:
//   hs_active=1, all-zero data for 64 clk -> sync_err single pulse at clk 64.
//   No byte_valid. Remains silent until hs_active=0, then 0xB8 after re-entry locks.
//  SYNC_TOL:
//   sync sent as 0xB9.
//   SYNC_TOL=0 -> no lock, sync_err. SYNC_TOL=1 -> lock, next byte 0x55 delivered.
//  Burst end:
//   drop hs_active mid-byte -> locked=0 and no byte_valid next edge.
//   Next burst relocks with pkt_start again.
//  Reset mid-burst:
//   assert rst asynchronously while locked -> all outputs 0 immediately, without a clk edge.
//   Sync data present at deassertion is hunted afresh.

Source files
------------

// File: rtl/csi2_lane_sync_if.sv
// rtl/csi2_lane_sync_if.sv - lane-side signals of one CSI-2 HS sync hunter/aligner
interface csi2_lane_sync_if;
  logic       hs_active;
  logic [1:0] din;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       pkt_start;
  logic       locked;
  logic       bit_phase;
  logic       sync_err;

  modport master (
    output hs_active, din,
    input  byte_out, byte_valid, pkt_start, locked, bit_phase, sync_err
  );

  modport slave (
    input  hs_active, din,
    output byte_out, byte_valid, pkt_start, locked, bit_phase, sync_err
  );
endinterface

// File: rtl/csi2_lane_sync.sv
// rtl/csi2_lane_sync.sv - per-lane HS sync-byte hunter and byte aligner (2 bits/clk in)
// Hunts the leader sync at either bit phase, then strobes one aligned byte every 4 clk.
module csi2_lane_sync #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 64,
  parameter int         SYNC_TOL     = 0
) (
  input logic             clk,
  input logic             rst,
  csi2_lane_sync_if.slave lane
);
  localparam int            HW        = $clog2(HUNT_TIMEOUT);
  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HUNT, SYNC, WAIT_LP} state_t;

  state_t        state;
  // Bit 0 of the 10-bit window is never inspected, so it is not stored.
  logic [9:1]    sr;
  logic [9:1]    sr_next;
  logic [HW-1:0] hunt_cnt;
  logic [1:0]    byte_cnt;
  logic          first;
  logic          m0;
  logic          m1;

  function automatic logic sync_match(input logic [7:0] window);
    logic [7:0] diff;
    diff = window ^ SYNC_BYTE;
    return (diff == 8'd0) ||
           ((SYNC_TOL != 0) && ((diff & (diff - 8'd1)) == 8'd0));
  endfunction

  assign sr_next = {lane.din, sr[9:3]};
  assign m0      = sync_match(sr[9:2]);
  assign m1      = sync_match(sr[8:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      sr              <= '0;
      hunt_cnt        <= '0;
      byte_cnt        <= 2'd0;
      first           <= 1'b0;
      lane.byte_out   <= 8'd0;
      lane.byte_valid <= 1'b0;
      lane.pkt_start  <= 1'b0;
      lane.locked     <= 1'b0;
      lane.bit_phase  <= 1'b0;
      lane.sync_err   <= 1'b0;
    end else begin
      sr              <= sr_next;
      lane.byte_valid <= 1'b0;
      lane.pkt_start  <= 1'b0;
      lane.sync_err   <= 1'b0;
      if (!lane.hs_active) begin
        state       <= IDLE;
        lane.locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= HUNT;
            hunt_cnt <= '0;
          end
          HUNT: begin
            hunt_cnt <= hunt_cnt + HW'(1);
            if (m0 || m1) begin
              state          <= SYNC;
              lane.locked    <= 1'b1;
              lane.bit_phase <= ~m0;
              byte_cnt       <= 2'd0;
              first          <= 1'b1;
            end else if (hunt_cnt == HUNT_LAST) begin
              state         <= WAIT_LP;
              lane.sync_err <= 1'b1;
            end
          end
          SYNC: begin
            byte_cnt <= byte_cnt + 2'd1;
            // The counter reaches 3 on this edge; the byte completes in the incoming pair.
            if (byte_cnt == 2'd2) begin
              lane.byte_out   <= lane.bit_phase ? sr_next[8:1] : sr_next[9:2];
              lane.byte_valid <= 1'b1;
              lane.pkt_start  <= first;
              first           <= 1'b0;
            end
          end
          WAIT_LP: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csi2_lane_sync.sv
// tb/tb_csi2_lane_sync.sv - directed bench for csi2_lane_sync (exact and tolerant sync)
module tb_csi2_lane_sync;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_active = 1'b0;
  logic [1:0] din = 2'b00;

  always #5 clk = ~clk;

  csi2_lane_sync_if lane0 ();
  csi2_lane_sync_if lane1 ();
  assign lane0.hs_active = hs_active;
  assign lane0.din       = din;
  assign lane1.hs_active = hs_active;
  assign lane1.din       = din;

  csi2_lane_sync #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(64), .SYNC_TOL(0)) dut0 (
    .clk(clk), .rst(rst), .lane(lane0));
  csi2_lane_sync #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(64), .SYNC_TOL(1)) dut1 (
    .clk(clk), .rst(rst), .lane(lane1));

  typedef struct {
    int         pad;
    logic [7:0] sync_b;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       exp_phase;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    int         exp_lock;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       ps;
    int         cyc;
  } ev_t;

  vec_t vt [6];
  ev_t  q0 [$];
  ev_t  q1 [$];
  logic bitq [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   c0;
  int   lock0_cyc, lock1_cyc, err0_n, err1_n, err0_cyc;
  int   back2back = 0;
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;
  ev_t  e0, e1;
  ev_t  none_ev = '{8'h00, 1'b0, -1000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic b0, b1;
    @(negedge clk);
    cyc++;
    if (lane0.byte_valid) q0.push_back('{lane0.byte_out, lane0.pkt_start, cyc});
    if (lane1.byte_valid) q1.push_back('{lane1.byte_out, lane1.pkt_start, cyc});
    if (lane0.byte_valid && prev_v0) back2back++;
    if (lane1.byte_valid && prev_v1) back2back++;
    prev_v0 = lane0.byte_valid;
    prev_v1 = lane1.byte_valid;
    if (lane0.locked && lock0_cyc < 0) lock0_cyc = cyc;
    if (lane1.locked && lock1_cyc < 0) lock1_cyc = cyc;
    if (lane0.sync_err) begin err0_n++; err0_cyc = cyc; end
    if (lane1.sync_err) err1_n++;
    b0 = 1'b0;
    b1 = 1'b0;
    if (bitq.size() > 0) b0 = bitq.pop_front();
    if (bitq.size() > 0) b1 = bitq.pop_front();
    din = {b1, b0};
  endtask

  task automatic clear_log();
    q0.delete();
    q1.delete();
    lock0_cyc = -1;
    lock1_cyc = -1;
    err0_n = 0;
    err1_n = 0;
    err0_cyc = -1;
  endtask

  task automatic push_zeros(input int n);
    for (int k = 0; k < n; k++) bitq.push_back(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) bitq.push_back(b[k]);
  endtask

  task automatic start_burst();
    hs_active = 1'b0;
    bitq.delete();
    repeat (3) step();
    clear_log();
    c0 = cyc;
    hs_active = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // lock delay = 3 + index of the pair carrying the last sync bit, (pad+7)/2
    vt[0] = '{8,  8'hB8, 8'h12, 8'h34, 1'b0, 8'h12, 8'h34, 10};
    vt[1] = '{9,  8'hB8, 8'h12, 8'h34, 1'b1, 8'h12, 8'h34, 11};
    vt[2] = '{0,  8'hB8, 8'hA5, 8'h5A, 1'b0, 8'hA5, 8'h5A, 6};
    vt[3] = '{3,  8'hB8, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 8};
    vt[4] = '{6,  8'hB8, 8'hB8, 8'h47, 1'b0, 8'hB8, 8'h47, 9};
    vt[5] = '{13, 8'hB8, 8'h01, 8'h80, 1'b1, 8'h01, 8'h80, 13};

    clear_log();
    repeat (2) step();
    check("reset locked", lane0.locked, 0);
    check("reset byte_valid", lane0.byte_valid, 0);
    check("reset byte_out", lane0.byte_out, 0);
    check("reset bit_phase", lane0.bit_phase, 0);
    check("reset pkt_start", lane0.pkt_start, 0);
    check("reset sync_err", lane0.sync_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_burst();
      push_zeros(vt[i].pad);
      push_byte(vt[i].sync_b);
      push_byte(vt[i].d1);
      push_byte(vt[i].d2);
      repeat (30) step();
      e0 = (q0.size() > 0) ? q0[0] : none_ev;
      e1 = (q0.size() > 1) ? q0[1] : none_ev;
      check($sformatf("vec%0d lock delay", i), lock0_cyc - c0, vt[i].exp_lock);
      check($sformatf("vec%0d bit_phase", i), lane0.bit_phase, vt[i].exp_phase);
      check($sformatf("vec%0d byte1", i), e0.b, vt[i].exp_b1);
      check($sformatf("vec%0d byte1 pkt_start", i), e0.ps, 1);
      check($sformatf("vec%0d byte1 latency", i), e0.cyc - lock0_cyc, 3);
      check($sformatf("vec%0d byte2", i), e1.b, vt[i].exp_b2);
      check($sformatf("vec%0d byte2 pkt_start", i), e1.ps, 0);
      check($sformatf("vec%0d byte spacing", i), e1.cyc - e0.cyc, 4);
      check($sformatf("vec%0d no sync_err", i), err0_n, 0);
    end

    // Hunt timeout, silence in WAIT_LP, then relock after re-entry.
    start_burst();
    repeat (80) step();
    check("timeout err count", err0_n, 1);
    check("timeout err cycle", err0_cyc - c0, 65);
    check("timeout no lock", lock0_cyc, -1);
    check("timeout no bytes", q0.size(), 0);
    push_zeros(8);
    push_byte(8'hB8);
    push_byte(8'h12);
    repeat (30) step();
    check("wait_lp no re-pulse", err0_n, 1);
    check("wait_lp no lock", lock0_cyc, -1);
    check("wait_lp no bytes", q0.size(), 0);
    start_burst();
    push_zeros(8);
    push_byte(8'hB8);
    push_byte(8'h12);
    repeat (25) step();
    e0 = (q0.size() > 0) ? q0[0] : none_ev;
    check("reentry lock delay", lock0_cyc - c0, 10);
    check("reentry byte", e0.b, 8'h12);
    check("reentry pkt_start", e0.ps, 1);

    // One-bit-off sync: exact instance times out, tolerant instance locks.
    start_burst();
    push_zeros(8);
    push_byte(8'hB9);
    push_byte(8'h55);
    repeat (80) step();
    e1 = (q1.size() > 0) ? q1[0] : none_ev;
    check("tol0 no lock", lock0_cyc, -1);
    check("tol0 sync_err count", err0_n, 1);
    check("tol0 sync_err cycle", err0_cyc - c0, 65);
    check("tol0 no bytes", q0.size(), 0);
    check("tol1 lock delay", lock1_cyc - c0, 10);
    check("tol1 no sync_err", err1_n, 0);
    check("tol1 byte", e1.b, 8'h55);
    check("tol1 pkt_start", e1.ps, 1);

    // Drop hs_active just before the second byte completes.
    start_burst();
    push_zeros(8);
    push_byte(8'hB8);
    push_byte(8'h12);
    push_byte(8'h34);
    repeat (16) step();
    e0 = (q0.size() > 0) ? q0[0] : none_ev;
    check("burst first byte", e0.b, 8'h12);
    check("burst first cycle", e0.cyc - c0, 13);
    hs_active = 1'b0;
    step();
    check("burst end locked", lane0.locked, 0);
    check("burst end byte_valid", lane0.byte_valid, 0);
    repeat (6) step();
    check("burst end byte count", q0.size(), 1);
    bitq.delete();
    clear_log();
    c0 = cyc;
    hs_active = 1'b1;
    push_zeros(8);
    push_byte(8'hB8);
    push_byte(8'h77);
    repeat (20) step();
    e0 = (q0.size() > 0) ? q0[0] : none_ev;
    check("relock delay", lock0_cyc - c0, 10);
    check("relock byte", e0.b, 8'h77);
    check("relock pkt_start", e0.ps, 1);

    // Asynchronous reset while locked at phase 1.
    start_burst();
    push_zeros(9);
    push_byte(8'hB8);
    push_byte(8'h12);
    push_byte(8'h34);
    repeat (20) step();
    check("pre-reset locked", lane0.locked, 1);
    check("pre-reset bit_phase", lane0.bit_phase, 1);
    check("pre-reset byte_out", lane0.byte_out, 8'h34);
    #2 rst = 1'b1;
    #1;
    check("async rst locked", lane0.locked, 0);
    check("async rst bit_phase", lane0.bit_phase, 0);
    check("async rst byte_out", lane0.byte_out, 0);
    check("async rst byte_valid", lane0.byte_valid, 0);
    check("async rst pkt_start", lane0.pkt_start, 0);
    check("async rst sync_err", lane0.sync_err, 0);
    bitq.delete();
    repeat (2) step();
    rst = 1'b0;
    clear_log();
    c0 = cyc;
    push_zeros(2);
    push_byte(8'hB8);
    push_byte(8'h9C);
    repeat (20) step();
    e0 = (q0.size() > 0) ? q0[0] : none_ev;
    check("post-reset lock delay", lock0_cyc - c0, 7);
    check("post-reset bit_phase", lane0.bit_phase, 0);
    check("post-reset byte", e0.b, 8'h9C);
    check("post-reset pkt_start", e0.ps, 1);

    check("byte_valid never back-to-back", back2back, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
